uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  UART serial receiver: 8N1 frames, LSB first. Stage directly downstream of the
//  baud rate generator. Each rising edge of that generator's BaudRate output is
//  one oversample tick (16 ticks per bit). Delivers each byte with a one-cycle
//  strobe to the CPU peripheral registers. Fully synchronous to sysclk.
// PARAMETERS
//  OVERSAMPLE   16  ticks per bit period; must be even and >= 4
//  DATA_BITS    8   data bits per frame
//  SYNC_STAGES  2   flip-flop stages in the rx synchroniser; must be >= 2
// PORTS
//  sysclk     in   1          system clock; all state changes on its rising edge
//  reset      in   1          synchronous, active-high reset
//  BaudRate   in   1          oversample clock level from the baud rate generator (sysclk domain)
//  rx         in   1          asynchronous serial line; idles high
//  rx_data    out  DATA_BITS  last correctly framed byte; holds until the next good frame
//  rx_status  out  1          1-cycle pulse: rx_data was updated this cycle
//  frame_err  out  1          1-cycle pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  Reset (sync, active-high)
//   - Outputs: rx_data=0, rx_status=0, frame_err=0.
//   - State=IDLE; all synchroniser stages=1; cnt=0; bit index=0.
//   - Registered copy of BaudRate=1, so a BaudRate that is high at reset release gives no tick.
//   - Reset asserted mid-frame abandons the frame with no pulse.
//  Tick generation
//   - tick=1 for exactly one sysclk cycle when BaudRate=1 and the registered copy=0.
//   - Edge detection only; BaudRate is not re-synchronised.
//  rx handling
//   - rx passes through SYNC_STAGES flip-flops; the last stage is rx_s.
//   - The FSM samples only rx_s, and only on tick cycles.
//  FSM states and transitions (all evaluated only on tick cycles)
//   - IDLE:   rx_s=0 -> START, cnt=0.
//   - START:  cnt==OVERSAMPLE/2-1: rx_s=1 -> IDLE (false start, no pulse);
//             rx_s=0 -> DATA, cnt=0, bit index=0. Otherwise cnt++.
//   - DATA:   cnt==OVERSAMPLE-1: shift rx_s into bit [index] (LSB first), cnt=0,
//             index++; after DATA_BITS samples -> STOP. Otherwise cnt++.
//   - STOP:   cnt==OVERSAMPLE-1: rx_s=1 -> rx_data<=shift reg, rx_status=1, -> IDLE;
//             rx_s=0 -> frame_err=1, rx_data unchanged, -> BREAK. Otherwise cnt++.
//   - BREAK:  rx_s=1 -> IDLE. A line held low (break) therefore yields one
//             frame_err and no further frames.
//  Timing and outputs
//   - Data and stop bits are sampled mid-bit, OVERSAMPLE ticks apart.
//   - rx_status/frame_err are registered: high in the sysclk cycle after the stop-bit
//     sample tick, low otherwise. They are never high together.
//   - rx_data changes only in the same cycle rx_status=1.
//   - A new start bit is accepted on the first tick after returning to IDLE, so
//     back-to-back frames with one stop bit are received without loss.
//   - cnt width: $clog2(OVERSAMPLE). Index width: $clog2(DATA_BITS+1). No wrap beyond the compare values.
// TESTING
//  Bench setup: BaudRate toggles every 4 sysclk (tick every 8 cycles); bit = 16 ticks.
//  1. Reset held 3 cycles, rx=1 -> rx_data=0, rx_status=0, frame_err=0; no pulses over 500 cycles.
//  2. Frame 0x55, then frame 0xA3 -> rx_data=0x55 then 0xA3; exactly one rx_status pulse each; frame_err=0.
//  3. rx low for 3 ticks, then high -> no rx_status, no frame_err; a following 0x3C frame is received correctly.
//  4. Frame 0x81 with stop bit=0, rx held low 40 ticks, then high, then frame 0x7E
//     -> one frame_err pulse; rx_data keeps the prior value until 0x7E is received with rx_status.
//  5. Back-to-back 0x00, 0xFF, 0x00 with no idle gap -> three rx_status pulses, with data in order.
//  6. reset pulsed during data bit 4 of 0xC5, then frame 0x12 -> no pulse for 0xC5; rx_data=0x12.

Source files
------------

// File: rtl/uart_receiver_if.sv
// CPU-facing side of the UART receiver: received byte plus its one-cycle
// status and framing-error strobes.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_status;
    logic                 frame_err;

    modport master (output rx_data, rx_status, frame_err);
    modport slave  (input  rx_data, rx_status, frame_err);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver sampling mid-bit on BaudRate oversample ticks; delivers
// each good byte with a one-cycle rx_status strobe, bad stop bits with frame_err.
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic            BaudRate,
    input  logic            rx,
    uart_receiver_if.master cpuBus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rxState_t;

    rxState_t               state, stateNext;
    logic [CNT_W-1:0]       cnt, cntNext;
    logic [IDX_W-1:0]       bitIdx, bitIdxNext;
    logic [DATA_BITS-1:0]   shiftReg, shiftNext;
    logic [DATA_BITS-1:0]   rxData, rxDataNext;
    logic                   rxStatus, rxStatusNext;
    logic                   frameErr, frameErrNext;
    logic                   baudQ;
    logic [SYNC_STAGES-1:0] rxSync;
    logic                   tick;
    logic                   rxS;

    // baudQ resets high so a BaudRate already high at reset release is not a tick.
    assign tick = BaudRate & ~baudQ;
    assign rxS  = rxSync[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            rxData   <= '0;
            rxStatus <= 1'b0;
            frameErr <= 1'b0;
            baudQ    <= 1'b1;
            rxSync   <= '1;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
            rxData   <= rxDataNext;
            rxStatus <= rxStatusNext;
            frameErr <= frameErrNext;
            baudQ    <= BaudRate;
            rxSync   <= {rxSync[SYNC_STAGES-2:0], rx};
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        bitIdxNext   = bitIdx;
        shiftNext    = shiftReg;
        rxDataNext   = rxData;
        rxStatusNext = 1'b0;
        frameErrNext = 1'b0;

        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rxS) begin
                        stateNext = START;
                        cntNext   = '0;
                    end
                end
                START: begin
                    // Half a bit in: still low means a real start bit.
                    if (cnt == HALF_LAST) begin
                        if (rxS) begin
                            stateNext = IDLE;
                        end else begin
                            stateNext  = DATA;
                            cntNext    = '0;
                            bitIdxNext = '0;
                        end
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (bitIdx == IDX_W'(i)) shiftNext[i] = rxS;
                        end
                        cntNext    = '0;
                        bitIdxNext = bitIdx + IDX_W'(1);
                        if (bitIdx == IDX_LAST) stateNext = STOP;
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cntNext = '0;
                        if (rxS) begin
                            rxDataNext   = shiftReg;
                            rxStatusNext = 1'b1;
                            stateNext    = IDLE;
                        end else begin
                            frameErrNext = 1'b1;
                            stateNext    = BREAK;
                        end
                    end else begin
                        cntNext = cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rxS) stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign cpuBus.rx_data   = rxData;
    assign cpuBus.rx_status = rxStatus;
    assign cpuBus.frame_err = frameErr;
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table-driven frames plus hand-written
// corner sequences, with a scoreboard of expected strobes.
module tb_uart_receiver;
    localparam int TICK_CYCLES = 8;
    localparam int BIT_CYCLES  = 16 * TICK_CYCLES;

    logic sysclk   = 1'b0;
    logic reset    = 1'b1;
    logic BaudRate = 1'b0;
    logic rx       = 1'b1;

    uart_receiver_if #(.DATA_BITS(8)) cpuBus ();

    uart_receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .BaudRate(BaudRate),
        .rx      (rx),
        .cpuBus  (cpuBus)
    );

    typedef struct {
        logic       isErr;
        logic [7:0] data;
    } pulse_t;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         gapBits;
        logic       expGood;
        logic [7:0] expData;
    } vec_t;

    pulse_t expQ[$];
    vec_t   vectors[5];
    int     checkCount    = 0;
    int     passCount     = 0;
    int     stabilityErrs = 0;
    int     overlapErrs   = 0;

    always #5 sysclk = ~sysclk;

    initial begin
        forever begin
            repeat (4) @(negedge sysclk);
            BaudRate = ~BaudRate;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks so far", passCount, checkCount);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        idleCycles(BIT_CYCLES);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        sendBit(stopBit);
    endtask

    task automatic expectGood(input logic [7:0] d);
        pulse_t p;
        p.isErr = 1'b0;
        p.data  = d;
        expQ.push_back(p);
    endtask

    task automatic expectErr();
        pulse_t p;
        p.isErr = 1'b1;
        p.data  = 8'h00;
        expQ.push_back(p);
    endtask

    task automatic runVector(input vec_t v);
        if (v.expGood) expectGood(v.expData);
        else expectErr();
        sendFrame(v.data, v.stopBit);
        idleCycles(v.gapBits * BIT_CYCLES);
    endtask

    // Scoreboard monitor, sampling 2 time units after each rising edge.
    initial begin
        logic [7:0] prevData;
        pulse_t     e;
        prevData = 8'h00;
        forever begin
            @(posedge sysclk);
            #2;
            if (reset) begin
                prevData = cpuBus.rx_data;
            end else begin
                if (cpuBus.rx_status && cpuBus.frame_err) overlapErrs++;
                if (!cpuBus.rx_status && cpuBus.rx_data !== prevData) stabilityErrs++;
                if (cpuBus.rx_status || cpuBus.frame_err) begin
                    if (expQ.size() == 0) begin
                        check("unexpected strobe {rx_status,frame_err}",
                              {30'd0, cpuBus.rx_status, cpuBus.frame_err}, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("strobe kind frame_err", cpuBus.frame_err, e.isErr);
                        if (!e.isErr) check("rx_data on rx_status", cpuBus.rx_data, e.data);
                    end
                end
                prevData = cpuBus.rx_data;
            end
        end
    end

    initial begin
        vectors[0] = '{8'h55, 1'b1, 2, 1'b1, 8'h55};
        vectors[1] = '{8'hA3, 1'b1, 2, 1'b1, 8'hA3};
        vectors[2] = '{8'h00, 1'b1, 0, 1'b1, 8'h00};
        vectors[3] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF};
        vectors[4] = '{8'h00, 1'b1, 2, 1'b1, 8'h00};

        // Reset and quiet idle line
        reset = 1'b1;
        rx    = 1'b1;
        idleCycles(3);
        reset = 1'b0;
        check("reset rx_data", cpuBus.rx_data, 8'h00);
        check("reset rx_status", cpuBus.rx_status, 1'b0);
        check("reset frame_err", cpuBus.frame_err, 1'b0);
        idleCycles(500);
        check("idle rx_data", cpuBus.rx_data, 8'h00);

        // Two ordinary frames
        for (int i = 0; i < 2; i++) runVector(vectors[i]);
        check("pending after 0x55/0xA3", expQ.size(), 0);
        check("rx_data after 0xA3", cpuBus.rx_data, 8'hA3);

        // Glitch shorter than half a bit is a false start
        rx = 1'b0;
        idleCycles(3 * TICK_CYCLES);
        rx = 1'b1;
        idleCycles(3 * BIT_CYCLES);
        check("rx_data after false start", cpuBus.rx_data, 8'hA3);
        expectGood(8'h3C);
        sendFrame(8'h3C, 1'b1);
        idleCycles(2 * BIT_CYCLES);
        check("rx_data after 0x3C", cpuBus.rx_data, 8'h3C);
        check("pending after 0x3C", expQ.size(), 0);

        // Bad stop bit followed by a long break
        expectErr();
        sendFrame(8'h81, 1'b0);
        idleCycles(40 * TICK_CYCLES);
        check("rx_data held through break", cpuBus.rx_data, 8'h3C);
        rx = 1'b1;
        idleCycles(2 * BIT_CYCLES);
        check("pending after break", expQ.size(), 0);
        check("rx_data held after break", cpuBus.rx_data, 8'h3C);
        expectGood(8'h7E);
        sendFrame(8'h7E, 1'b1);
        idleCycles(2 * BIT_CYCLES);
        check("rx_data after 0x7E", cpuBus.rx_data, 8'h7E);

        // Back-to-back frames, one stop bit, no idle gap
        for (int i = 2; i < 5; i++) runVector(vectors[i]);
        check("pending after back-to-back", expQ.size(), 0);
        check("rx_data after back-to-back", cpuBus.rx_data, 8'h00);

        // Reset mid-frame during data bit 4 of 0xC5
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'(8'hC5 >> i));
        rx = 1'b0;
        idleCycles(BIT_CYCLES / 2);
        reset = 1'b1;
        rx    = 1'b1;
        idleCycles(2);
        reset = 1'b0;
        check("rx_data after mid-frame reset", cpuBus.rx_data, 8'h00);
        check("rx_status after mid-frame reset", cpuBus.rx_status, 1'b0);
        idleCycles(3 * BIT_CYCLES);
        check("pending after mid-frame reset", expQ.size(), 0);
        expectGood(8'h12);
        sendFrame(8'h12, 1'b1);
        idleCycles(2 * BIT_CYCLES);
        check("rx_data after 0x12", cpuBus.rx_data, 8'h12);

        check("pending at end", expQ.size(), 0);
        check("rx_data changes without rx_status", stabilityErrs, 0);
        check("rx_status and frame_err together", overlapErrs, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
